// File: rtl/phase_nco_pkg.sv
// Shared definitions for the multi-channel phase NCO.
package phase_nco_pkg;

    `include "nco_defs.vh"

    // Encoding 2'b11 is not listed above and behaves as wrap.
    function automatic logic mode_is_bounce(input logic [1:0] mode);
        return mode == MODE_BOUNCE;
    endfunction

endpackage

// File: rtl/nco_defs.vh
// Phase-update mode encodings shared by the NCO design files.
`ifndef NCO_DEFS_VH
`define NCO_DEFS_VH

localparam logic [1:0] MODE_WRAP   = 2'b00;
localparam logic [1:0] MODE_SAT    = 2'b01;
localparam logic [1:0] MODE_BOUNCE = 2'b10;

`endif

// File: rtl/nco_table_ram.sv
// Lookup table: one byte-masked write port, one synchronous read port.
// A read and a write to the same address on the same edge returns the old word.
module nco_table_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   wmask_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write into the table array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wmask_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read, one cycle of latency.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/phase_nco.sv
// Time-multiplexed phase accumulator NCO: NCH channels share one table read
// port, each channel serviced in its own slot of a rotating slot counter.
module phase_nco
    import phase_nco_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8,
    parameter int FRAC_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NCH-1:0]                   ch_en,
    input  logic [NCH-1:0]                   ch_preload,
    input  logic [NCH-1:0]                   ch_up_dn,
    input  logic [2*NCH-1:0]                 ch_mode,
    input  logic [NCH*(ADDR_W+FRAC_W)-1:0]   ch_step,
    input  logic [NCH*(ADDR_W+FRAC_W)-1:0]   pl_data,
    input  logic                             tbl_we,
    input  logic [DATA_W/8-1:0]              tbl_wmask,
    input  logic [ADDR_W-1:0]                tbl_addr,
    input  logic [DATA_W-1:0]                tbl_wdata,
    output logic [NCH*DATA_W-1:0]            dout,
    output logic [NCH-1:0]                   dout_valid,
    output logic [NCH*(ADDR_W+FRAC_W)-1:0]   phase
);

    localparam int PH_W   = ADDR_W + FRAC_W;
    localparam int SLOT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH - 1);
    localparam logic [PH_W-1:0]   PH_MAX    = '1;

    // Returns {direction toggle, new phase}. Sum/difference carry one extra bit
    // so overflow/underflow is visible; an exact hit on a limit is not a bounce.
    function automatic logic [PH_W:0] advance_phase(
        input logic [PH_W-1:0] ph,
        input logic [PH_W-1:0] step,
        input logic            up,
        input logic [1:0]      mode
    );
        logic [PH_W:0]   sum;
        logic [PH_W:0]   diff;
        logic [PH_W-1:0] res;
        logic            tog;
        sum  = {1'b0, ph} + {1'b0, step};
        diff = {1'b0, ph} - {1'b0, step};
        tog  = 1'b0;
        if (up) begin
            res = sum[PH_W-1:0];
            if (sum[PH_W]) begin
                if (mode == MODE_SAT) begin
                    res = PH_MAX;
                end else if (mode_is_bounce(mode)) begin
                    res = PH_W'({PH_MAX, 1'b0} - sum);
                    tog = 1'b1;
                end
            end
        end else begin
            res = diff[PH_W-1:0];
            if (diff[PH_W]) begin
                if (mode == MODE_SAT) begin
                    res = '0;
                end else if (mode_is_bounce(mode)) begin
                    res = PH_W'(-diff);
                    tog = 1'b1;
                end
            end
        end
        return {tog, res};
    endfunction

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PH_W-1:0]   phase_q [NCH];
    logic [PH_W-1:0]   phase_d [NCH];
    logic [PH_W:0]     adv     [NCH];
    logic [NCH-1:0]    dir_q, dir_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic              vld_p0, vld_p1;
    logic [SLOT_W-1:0] slot_p0, slot_p1;
    logic [DATA_W-1:0] data_p1;
    logic [DATA_W-1:0] dout_q [NCH];
    logic [NCH-1:0]    dout_valid_q;

    // The serviced channel's integer phase addresses the table, before its update.
    assign rd_addr = phase_q[slot_q][PH_W-1:FRAC_W];
    assign slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

    // Next phase and direction: preload beats advance beats hold, only in own slot.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            adv[k]     = advance_phase(phase_q[k], ch_step[k*PH_W +: PH_W],
                                       ch_up_dn[k] ^ dir_q[k], ch_mode[2*k +: 2]);
            phase_d[k] = phase_q[k];
            dir_d[k]   = dir_q[k];
            if (slot_q == SLOT_W'(k)) begin
                if (ch_preload[k]) begin
                    phase_d[k] = pl_data[k*PH_W +: PH_W];
                    dir_d[k]   = 1'b0;
                end else if (ch_en[k]) begin
                    phase_d[k] = adv[k][PH_W-1:0];
                    dir_d[k]   = dir_q[k] ^ adv[k][PH_W];
                end
            end
            if (!mode_is_bounce(ch_mode[2*k +: 2])) begin
                dir_d[k] = 1'b0;
            end
        end
    end

    // Slot counter, accumulators and direction flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
            dir_q  <= '0;
            for (int k = 0; k < NCH; k++) phase_q[k] <= '0;
        end else begin
            slot_q <= slot_d;
            dir_q  <= dir_d;
            for (int k = 0; k < NCH; k++) phase_q[k] <= phase_d[k];
        end
    end

    // Writes are blocked during reset; table contents themselves survive reset.
    nco_table_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .clk_i   (clk),
        .we_i    (tbl_we & ~reset),
        .wmask_i (tbl_wmask),
        .waddr_i (tbl_addr),
        .wdata_i (tbl_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    // Read-pipeline valids: reset flushes every read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // Read-pipeline payload: issuing slot travels with the table word.
    always_ff @(posedge clk) begin
        slot_p0 <= slot_q;
        slot_p1 <= slot_p0;
        data_p1 <= rdata;
    end

    // Land the word in the issuing channel's output and pulse only its valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid_q <= '0;
            for (int k = 0; k < NCH; k++) dout_q[k] <= '0;
        end else begin
            dout_valid_q <= '0;
            if (vld_p1) begin
                dout_valid_q[slot_p1] <= 1'b1;
                dout_q[slot_p1]       <= data_p1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign dout[g*DATA_W +: DATA_W] = dout_q[g];
        assign phase[g*PH_W +: PH_W]    = phase_q[g];
    end
    assign dout_valid = dout_valid_q;

endmodule
